fixed_subframe_sequencer: RTL and testbench

//  Sequences one FLAC FIXED subframe through the external FixedDecoder datapath.

---
 rtl/flac_fixed_pkg.sv | 16 +
 rtl/fixed_seq_valid_pipe.sv | 32 +++
 rtl/fixed_subframe_sequencer.sv | 128 ++++++++++++
 tb/tb_fixed_subframe_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flac_fixed_pkg.sv
// Shared types and constants for the FLAC FIXED subframe sequencer.
package flac_fixed_pkg;

  localparam int SAMPLE_W        = 32;
  localparam int ORDER_W         = 8;
  localparam int MAX_FIXED_ORDER = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fixed_seq_valid_pipe.sv
// Valid-bit delay line that matches the external decoder latency; flush drops
// anything in flight.
module fixed_seq_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in,
  output logic out
);

  logic [DEPTH-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sr[i] <= sr[i-1];
      end
      sr[0] <= in;
    end
  end

  assign out = sr[DEPTH-1];

endmodule

// File: rtl/fixed_subframe_sequencer.sv
// Streams one FLAC FIXED subframe through the external decoder and counts its outputs.
// Optional order check enabled by defining FIXED_SEQ_ORDER_CHECK_EN.
module fixed_subframe_sequencer
  import flac_fixed_pkg::*;
#(
  parameter int DEC_LATENCY = 1,
  parameter int BS_W        = 16
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [ORDER_W-1:0]  iOrder,
  input  logic [BS_W-1:0]     iBlockSize,
  input  logic                iInValid,
  input  logic [SAMPLE_W-1:0] iInSample,
  output logic                oInReady,
  output logic                oDecReset,
  output logic                oDecEnable,
  output logic [ORDER_W-1:0]  oDecOrder,
  output logic [SAMPLE_W-1:0] oDecSample,
  input  logic [SAMPLE_W-1:0] iDecData,
  output logic                oOutValid,
  output logic [SAMPLE_W-1:0] oOutSample,
  output logic                oBusy,
  output logic                oDone,
  output logic                oError
);

  state_t             state, state_next;
  logic [ORDER_W-1:0] order_q;
  logic [BS_W-1:0]    size_q;
  logic [BS_W-1:0]    in_count;
  logic [BS_W-1:0]    out_count;
  logic               beat;
  logic               pipe_valid;
  logic               start_ok;

  assign beat = iInValid & oInReady;

`ifdef FIXED_SEQ_ORDER_CHECK_EN
  logic error_q;
  assign start_ok = (iOrder <= ORDER_W'(MAX_FIXED_ORDER));

  // Error is re-evaluated on every accepted start, so it clears on a good one.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      error_q <= 1'b0;
    end else if (state == IDLE && iStart) begin
      error_q <= !start_ok;
    end
  end
  assign oError = error_q;
`else
  assign start_ok = 1'b1;
  assign oError   = 1'b0;
`endif

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      order_q   <= '0;
      size_q    <= '0;
      in_count  <= '0;
      out_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && iStart) begin
        order_q   <= iOrder;
        size_q    <= iBlockSize;
        in_count  <= '0;
        out_count <= '0;
      end else begin
        if (beat)      in_count  <= in_count + BS_W'(1);
        if (pipe_valid) out_count <= out_count + BS_W'(1);
      end
    end
  end

  // NOTE: every signal driven here gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_next = state;
    oInReady   = 1'b0;
    oDecReset  = 1'b0;
    oDone      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) state_next = start_ok ? CLEAR : DONE;
      end
      CLEAR: begin
        oDecReset  = 1'b1;
        state_next = (size_q == '0) ? DONE : RUN;
      end
      RUN: begin
        oInReady = 1'b1;
        if (iInValid && in_count == size_q - BS_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_count == size_q) state_next = DONE;
      end
      DONE: begin
        oDone      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign oBusy      = (state != IDLE);
  assign oDecEnable = beat;
  assign oDecSample = beat ? iInSample : '0;
  assign oDecOrder  = order_q;

  // The decoder provides the pipeline delay; this only tracks which cycles carry data.
  fixed_seq_valid_pipe #(
    .DEPTH (DEC_LATENCY)
  ) u_valid_pipe (
    .clk   (iClock),
    .rst   (iReset),
    .flush (oDecReset),
    .in    (beat),
    .out   (pipe_valid)
  );

  assign oOutValid  = pipe_valid;
  assign oOutSample = pipe_valid ? iDecData : '0;

endmodule

// File: tb/tb_fixed_subframe_sequencer.sv
// Scoreboard bench for fixed_subframe_sequencer with a behavioural FIXED decoder.
`timescale 1ns/1ps
module tb_fixed_subframe_sequencer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic [7:0]  iOrder = '0;
  logic [15:0] iBlockSize = '0;
  logic        iInValid = 1'b0;
  logic [31:0] iInSample = '0;
  logic [31:0] iDecData;
  logic        oInReady, oDecReset, oDecEnable, oOutValid, oBusy, oDone, oError;
  logic [7:0]  oDecOrder;
  logic [31:0] oDecSample, oOutSample;

  fixed_subframe_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iOrder(iOrder),
    .iBlockSize(iBlockSize), .iInValid(iInValid), .iInSample(iInSample),
    .oInReady(oInReady), .oDecReset(oDecReset), .oDecEnable(oDecEnable),
    .oDecOrder(oDecOrder), .oDecSample(oDecSample), .iDecData(iDecData),
    .oOutValid(oOutValid), .oOutSample(oOutSample), .oBusy(oBusy),
    .oDone(oDone), .oError(oError)
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int dec_en_cnt = 0, dec_rst_cnt = 0, done_cnt = 0, out_cnt = 0;
  int cyc = 0, last_out_cyc = 0, done_cyc = 0;
  bit prev_beat = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural FIXED decoder, one cycle of latency, history held across bubbles.
  int h1, h2, h3, h4, nsamp, y, s;
  always @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      iDecData <= '0;
      h1 = 0; h2 = 0; h3 = 0; h4 = 0; nsamp = 0;
    end else if (oDecReset) begin
      h1 = 0; h2 = 0; h3 = 0; h4 = 0; nsamp = 0;
    end else if (oDecEnable) begin
      s = $signed(oDecSample);
      if (nsamp < int'(oDecOrder)) y = s;
      else begin
        case (oDecOrder)
          8'd1:    y = s + h1;
          8'd2:    y = s + 2*h1 - h2;
          8'd3:    y = s + 3*h1 - 3*h2 + h3;
          8'd4:    y = s + 4*h1 - 6*h2 + 4*h3 - h4;
          default: y = s;
        endcase
      end
      h4 = h3; h3 = h2; h2 = h1; h1 = y; nsamp++;
      iDecData <= y;
    end
  end

  always @(posedge iClock) cyc++;

  // Monitor: pops the scoreboard on every output and tracks strobes.
  always @(negedge iClock) begin
    if (iReset) begin
      prev_beat = 1'b0;
    end else begin
      if (oOutValid || prev_beat) check("out_latency", int'(oOutValid), int'(prev_beat));
      if (oOutValid) begin
        if (exp_q.size() == 0) check("spurious_out", int'(oOutValid), 0);
        else check("out_sample", $signed(oOutSample), exp_q.pop_front());
        out_cnt++;
        last_out_cyc = cyc;
      end
      if (oDecEnable) dec_en_cnt++;
      if (oDecReset)  dec_rst_cnt++;
      if (oDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_beat = oDecEnable;
    end
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic start(input int ord, input int bs);
    iStart = 1'b1;
    iOrder = ord[7:0];
    iBlockSize = bs[15:0];
    tick();
    iStart = 1'b0;
  endtask

  task automatic feed(input int vin[4], input int cnt, input bit bubble, input bit glitch);
    int idx = 0;
    int n = 0;
    bit gap = 1'b0;
    bit acc;
    bit glitched = 1'b0;
    while (idx < cnt && n < 200) begin
      iInValid  = !(bubble && gap);
      iInSample = vin[idx];
      if (glitch && idx == 2 && !glitched) begin
        iStart = 1'b1; iOrder = 8'd0; iBlockSize = 16'd1; glitched = 1'b1;
      end
      @(negedge iClock);
      acc = iInValid && oInReady;
      tick();
      iStart = 1'b0;
      if (acc) idx++;
      gap = !gap;
      n++;
    end
    iInValid = 1'b0;
    check("feed_budget", idx, cnt);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 50) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_sub(input int ord, input int bs, input int vin[4], input int vexp[4],
                         input bit bubble, input bit glitch);
    int d0 = done_cnt;
    for (int i = 0; i < bs; i++) exp_q.push_back(vexp[i]);
    start(ord, bs);
    check("busy_after_start", int'(oBusy), 1);
    feed(vin, bs, bubble, glitch);
    check("order_held", int'(oDecOrder), ord);
    wait_done(d0);
    repeat (3) tick();
    check("done_once", done_cnt - d0, 1);
    check("done_after_last", int'(done_cyc > last_out_cyc), 1);
    check("idle_after_done", int'(oBusy), 0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  int in_vec[4] = '{10, -7, -4, 8};
  int exp0[4]   = '{10, -7, -4, 8};
  int exp1[4]   = '{10, 3, -1, 7};
  int exp2[4]   = '{10, -7, -28, -41};
  int exp3[4]   = '{10, -7, -4, 27};
  int d0, e0, r0, o0;

  initial begin
    repeat (3) tick();
    check("rst_busy", int'(oBusy), 0);
    check("rst_done", int'(oDone), 0);
    check("rst_out_valid", int'(oOutValid), 0);
    check("rst_dec_order", int'(oDecOrder), 0);
    iReset = 1'b0;
    tick();

    // Valid input while idle must not reach the decoder.
    e0 = dec_en_cnt;
    iInValid = 1'b1; iInSample = 32'd99;
    repeat (3) tick();
    check("idle_ready", int'(oInReady), 0);
    check("idle_no_enable", dec_en_cnt - e0, 0);
    iInValid = 1'b0;

    run_sub(0, 4, in_vec, exp0, 1'b0, 1'b0);
    run_sub(1, 4, in_vec, exp1, 1'b0, 1'b0);
    run_sub(2, 4, in_vec, exp2, 1'b0, 1'b1);
    run_sub(3, 4, in_vec, exp3, 1'b1, 1'b0);

    // Empty subframe: clear, then done, with nothing emitted.
    d0 = done_cnt; o0 = out_cnt;
    start(0, 0);
    check("bs0_clear", int'(oDecReset), 1);
    check("bs0_no_done_yet", int'(oDone), 0);
    tick();
    check("bs0_done", int'(oDone), 1);
    tick();
    check("bs0_done_pulse", int'(oDone), 0);
    check("bs0_idle", int'(oBusy), 0);
    check("bs0_done_count", done_cnt - d0, 1);
    check("bs0_no_out", out_cnt - o0, 0);

    // Reset after two accepted beats; the second output is flushed by the reset.
    d0 = done_cnt;
    exp_q.push_back(10);
    start(1, 4);
    feed(in_vec, 2, 1'b0, 1'b0);
    iReset = 1'b1;
    #2;
    check("mid_rst_busy", int'(oBusy), 0);
    check("mid_rst_ready", int'(oInReady), 0);
    check("mid_rst_valid", int'(oOutValid), 0);
    check("mid_rst_sample", int'(oOutSample), 0);
    check("mid_rst_order", int'(oDecOrder), 0);
    tick();
    iReset = 1'b0;
    repeat (3) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_queue", exp_q.size(), 0);

`ifdef FIXED_SEQ_ORDER_CHECK_EN
    d0 = done_cnt; e0 = dec_en_cnt; r0 = dec_rst_cnt;
    iInValid = 1'b1; iInSample = 32'd5;
    start(5, 2);
    check("err_set", int'(oError), 1);
    wait_done(d0);
    repeat (3) tick();
    iInValid = 1'b0;
    check("err_no_enable", dec_en_cnt - e0, 0);
    check("err_no_clear", dec_rst_cnt - r0, 0);
    check("err_sticky", int'(oError), 1);
    run_sub(0, 2, in_vec, exp0, 1'b0, 1'b0);
    check("err_cleared", int'(oError), 0);
`else
    run_sub(5, 2, in_vec, exp0, 1'b0, 1'b0);
    check("no_err", int'(oError), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
